rot_patch_sampler: RTL and testbench

Sequencer for SIFT descriptor sampling over one keypoint's rotated 16x16 neighbourhood. On each start it scans the 256 patch positions in raster order and drives the shared 8-bit address bus of the per-direction rotation ROM bank. It adds the returned signed 5-bit offsets to the keypoint centre, range-checks the result against the image, and streams sample coordinates plus 4x4 cell index to the gradient-fetch/histogram stage over a valid/ready handshake.

---
 rtl/rot_patch_sampler.sv | 140 ++++++++++++++
 tb/tb_rot_patch_sampler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_patch_sampler.sv
// rot_patch_sampler: scans a keypoint's rotated 16x16 patch in raster order.
// Each position's ROM offset is added to the keypoint centre, and the result is
// streamed over a valid/ready handshake with its 4x4 cell index and an
// out-of-bounds flag.
// Optional build macro ROT_SKIP_OOB_EN: out-of-bounds samples are dropped
// instead of being emitted with out_oob set.
module rot_patch_sampler #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] kp_x,
  input  logic [CW-1:0] kp_y,
  input  logic [3:0]    kp_dir,
  output logic [3:0]    rom_dir,
  output logic [7:0]    rom_a,
  input  logic [4:0]    rom_dx,
  input  logic [4:0]    rom_dy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW:0]   out_x,
  output logic [CW:0]   out_y,
  output logic [3:0]    out_cell,
  output logic          out_oob,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e        r_state;
  logic [7:0]    r_idx;
  logic [CW-1:0] r_kp_x;
  logic [CW-1:0] r_kp_y;
  logic [3:0]    r_dir;
  logic          r_out_valid;
  logic [CW:0]   r_out_x;
  logic [CW:0]   r_out_y;
  logic [3:0]    r_out_cell;
  logic          r_out_oob;
  logic          r_busy;
  logic          r_done;

  logic [CW:0]   w_x;
  logic [CW:0]   w_y;
  logic          w_oob;
  logic          w_adv;
  logic          w_load;
  logic          w_step;

  // Centre plus sign-extended ROM offset, then range check against the image.
  always_comb begin
    w_x   = {1'b0, r_kp_x} + {{(CW - 4){rom_dx[4]}}, rom_dx};
    w_y   = {1'b0, r_kp_y} + {{(CW - 4){rom_dy[4]}}, rom_dy};
    w_oob = w_x[CW] || (w_x[CW-1:0] >= CW'(IMG_W)) ||
            w_y[CW] || (w_y[CW-1:0] >= CW'(IMG_H));
    w_adv = !r_out_valid || out_ready;
`ifdef ROT_SKIP_OOB_EN
    // Dropped samples need no register slot, so they never stall the scan.
    w_load = w_adv && !w_oob;
    w_step = w_load || w_oob;
`else
    w_load = w_adv;
    w_step = w_adv;
`endif
  end

  // Sequencer FSM with the output register; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= 8'd0;
      r_kp_x      <= '0;
      r_kp_y      <= '0;
      r_dir       <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_cell  <= 4'd0;
      r_out_oob   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_kp_x  <= kp_x;
            r_kp_y  <= kp_y;
            r_dir   <= kp_dir;
            r_idx   <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= StScan;
          end
        end
        StScan: begin
          if (w_load) begin
            r_out_x     <= w_x;
            r_out_y     <= w_y;
            r_out_cell  <= {r_idx[7:6], r_idx[3:2]};
            r_out_oob   <= w_oob;
            r_out_valid <= 1'b1;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_step) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == 8'd255) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          // Finishes on the final handshake, or at once if nothing is pending.
          if (w_adv) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rom_a     = r_idx;
  assign rom_dir   = r_dir;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_cell  = r_out_cell;
  assign out_oob   = r_out_oob;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_rot_patch_sampler.sv
// Directed bench for rot_patch_sampler with a behavioural ROM stub and a
// scoreboard of expected beats filled when each scan is launched.
module tb_rot_patch_sampler;

`ifdef ROT_SKIP_OOB_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  kp_x;
  logic [9:0]  kp_y;
  logic [3:0]  kp_dir;
  logic [3:0]  rom_dir;
  logic [7:0]  rom_a;
  logic [4:0]  rom_dx;
  logic [4:0]  rom_dy;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_x;
  logic [10:0] out_y;
  logic [3:0]  out_cell;
  logic        out_oob;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int done_cnt = 0;
  int cyc = 0;
  int t0 = 0;
  int mode = 0;
  int n_exp;
  int lat;
  logic [26:0] sb_q[$];
  logic [26:0] eb;

  rot_patch_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kp_x      (kp_x),
    .kp_y      (kp_y),
    .kp_dir    (kp_dir),
    .rom_dir   (rom_dir),
    .rom_a     (rom_a),
    .rom_dx    (rom_dx),
    .rom_dy    (rom_dy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_cell  (out_cell),
    .out_oob   (out_oob),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ROM stub model: mode 1 is a constant dx=-5, dy=0 table.
  function automatic logic [4:0] m_dx(logic [7:0] a, logic [3:0] d, int md);
    if (md == 1) return 5'h1b;
    if (a == 8'd0) return 5'h0b;
    return 5'(int'(a) * 7 + int'(d) * 3 + 5);
  endfunction

  function automatic logic [4:0] m_dy(logic [7:0] a, logic [3:0] d, int md);
    if (md == 1) return 5'h00;
    if (a == 8'd0) return 5'h1f;
    return 5'(int'(a) * 13 + int'(d));
  endfunction

  always_comb begin
    rom_dx = m_dx(rom_a, rom_dir, mode);
    rom_dy = m_dy(rom_a, rom_dir, mode);
  end

  // Expected beat {x, y, cell, oob} for patch position a.
  function automatic logic [26:0] exp_beat(int a, int kx, int ky, int d, int md);
    logic [7:0] av;
    logic [4:0] dx;
    logic [4:0] dy;
    int ex;
    int ey;
    logic oob;
    av  = 8'(a);
    dx  = m_dx(av, 4'(d), md);
    dy  = m_dy(av, 4'(d), md);
    ex  = kx + int'({{27{dx[4]}}, dx});
    ey  = ky + int'({{27{dy[4]}}, dy});
    oob = (ex < 0) || (ex >= 640) || (ey < 0) || (ey >= 480);
    return {11'(ex), 11'(ey), av[7:6], av[3:2], oob};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fill the scoreboard, pulse start and check the cycle after acceptance.
  task automatic launch(input int kx, input int ky, input int d);
    logic [26:0] b;
    sb_q.delete();
    n_exp = 0;
    for (int a = 0; a < 256; a++) begin
      b = exp_beat(a, kx, ky, d, mode);
      if (!(Skip && b[0])) begin
        sb_q.push_back(b);
        n_exp++;
      end
    end
    @(posedge clk);
    #1;
    beats    = 0;
    done_cnt = 0;
    start    = 1'b1;
    kp_x     = 10'(kx);
    kp_y     = 10'(ky);
    kp_dir   = 4'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
    check("busy_t1", {31'b0, busy}, 32'd1);
    check("rom_a_t1", {24'b0, rom_a}, 32'd0);
    check("rom_dir", {28'b0, rom_dir}, 32'(d));
  endtask

  task automatic wait_done();
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    check("beat_count", 32'(beats), 32'(n_exp));
    check("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (beats >= n) break;
    end
    check("reach_beats", 32'(beats), 32'(n));
  endtask

  // Scoreboard consumer: every handshake pops and compares one expected beat.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      beats++;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        eb = sb_q.pop_front();
        check("beat", {5'b0, out_x, out_y, out_cell, out_oob}, {5'b0, eb});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    kp_x      = '0;
    kp_y      = '0;
    kp_dir    = '0;
    out_ready = 1'b1;

    // Reset values
    @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rom_a", {24'b0, rom_a}, 32'd0);
    check("rst_rom_dir", {28'b0, rom_dir}, 32'd0);
    check("rst_out", {5'b0, out_x, out_y, out_cell, out_oob}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full scan, ready high: first beat at T+2, done at T+258
    mode = 0;
    launch(100, 50, 15);
    @(negedge clk);
    check("t1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("t2_valid", {31'b0, out_valid}, 32'd1);
    check("t2_x", {21'b0, out_x}, 32'd111);
    check("t2_y", {21'b0, out_y}, 32'd49);
    check("t2_cell", {28'b0, out_cell}, 32'd0);
    check("t2_oob", {31'b0, out_oob}, 32'd0);
    wait_done();
    check("done_latency", 32'(lat), 32'd257);
    repeat (4) @(negedge clk);
    check("done_once_1", 32'(done_cnt), 32'd1);

    // Backpressure for 5 cycles while sample 3 is valid
    launch(300, 200, 3);
    wait_beats(3);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_beat", {5'b0, out_x, out_y, out_cell, out_oob},
            {5'b0, exp_beat(3, 300, 200, 3, 0)});
      check("hold_rom_a", {24'b0, rom_a}, 32'd4);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();

    // Negative coordinate: kp=(2,2), dx=-5
    mode = 1;
    launch(2, 2, 0);
    @(negedge clk);
    @(negedge clk);
`ifndef ROT_SKIP_OOB_EN
    check("neg_x", {21'b0, out_x}, 32'h7fd);
    check("neg_oob", {31'b0, out_oob}, 32'd1);
`endif
    wait_done();
    mode = 0;

    // start while busy is ignored
    launch(500, 400, 7);
    wait_beats(40);
    #1;
    start  = 1'b1;
    kp_x   = 10'd5;
    kp_y   = 10'd5;
    kp_dir = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("dir_kept", {28'b0, rom_dir}, 32'd7);
    wait_done();
    repeat (5) @(negedge clk);
    check("done_once_4", 32'(done_cnt), 32'd1);
    check("idle_after_4", {31'b0, busy}, 32'd0);

    // Reset mid-scan aborts, fresh start resumes at rom_a=0
    launch(200, 100, 9);
    wait_beats(100);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", {31'b0, busy}, 32'd0);
    launch(200, 100, 9);
    wait_done();

    // Keypoint at the image corner: many out-of-range samples
    launch(0, 0, 4);
    wait_done();
    repeat (5) @(negedge clk);
    check("done_once_6", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
